// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Opcode map, ALU function codes and sequencer state type
//                shared by the fetch/decode unit, register file and ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   // Opcode field values (instr[8:5])
   localparam logic [3:0] OP_CPYIN  = 4'h0;
   localparam logic [3:0] OP_CPYOUT = 4'h1;
   localparam logic [3:0] OP_LOAD   = 4'h2;
   localparam logic [3:0] OP_STORE  = 4'h3;
   localparam logic [3:0] OP_ADD    = 4'h4;
   localparam logic [3:0] OP_SUB    = 4'h5;
   localparam logic [3:0] OP_AND    = 4'h6;
   localparam logic [3:0] OP_OR     = 4'h7;
   localparam logic [3:0] OP_BZ     = 4'h8;
   localparam logic [3:0] OP_JMP    = 4'h9;
   localparam logic [3:0] OP_COMP   = 4'hA;
   localparam logic [3:0] OP_HALT   = 4'hF;

   // ALU function select
   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // True when the instruction replaces pc+1 with pc+offset
   function automatic logic redirect(input logic [3:0] op, input logic zero);
      return (op == OP_JMP) || ((op == OP_BZ) && zero);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fetch_decode_if
//  Description : Instruction-memory port plus decoded control strobes
//                between the sequencer (master) and the datapath (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_decode_if #(
   parameter int PC_W = 8,
   parameter int IW   = 9
);
   logic [PC_W-1:0] imem_addr;
   logic [IW-1:0]   imem_data;
   logic            res_zero;
   logic            cpyin;
   logic            cpyout;
   logic            memLoad;
   logic            comp;
   logic            mem_write;
   logic [2:0]      reg_sel;
   logic [2:0]      alu_op;

   modport master (
      output imem_addr, cpyin, cpyout, memLoad, comp, mem_write, reg_sel, alu_op,
      input  imem_data, res_zero
   );

   modport slave (
      input  imem_addr, cpyin, cpyout, memLoad, comp, mem_write, reg_sel, alu_op,
      output imem_data, res_zero
   );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational opcode decoder; every output is forced to zero
//                unless en_i is high (the sequencer drives it with EXEC).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
   import cpu_pkg::*;
(
   input  wire logic [3:0] opcode_i,
   input  wire logic       en_i,
   output logic            cpyin_o,
   output logic            cpyout_o,
   output logic            memLoad_o,
   output logic            mem_write_o,
   output logic            comp_o,
   output logic [2:0]      alu_op_o
);

   // Opcode to strobe mapping; unlisted opcodes (branches, NOPs, HALT) assert nothing
   always_comb begin
      cpyin_o     = 1'b0;
      cpyout_o    = 1'b0;
      memLoad_o   = 1'b0;
      mem_write_o = 1'b0;
      comp_o      = 1'b0;
      alu_op_o    = ALU_PASS;
      if (en_i) begin
         case (opcode_i)
            OP_CPYIN:  cpyin_o     = 1'b1;
            OP_CPYOUT: cpyout_o    = 1'b1;
            OP_LOAD:   memLoad_o   = 1'b1;
            OP_STORE:  mem_write_o = 1'b1;
            OP_ADD:    alu_op_o    = ALU_ADD;
            OP_SUB:    alu_op_o    = ALU_SUB;
            OP_AND:    alu_op_o    = ALU_AND;
            OP_OR:     alu_op_o    = ALU_OR;
            OP_COMP: begin
               comp_o   = 1'b1;
               alu_op_o = ALU_SUB;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode
//  Description : Non-pipelined two-cycle instruction sequencer (FETCH, EXEC)
//                with PC update, relative branches and a sticky HALT state.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode
   import cpu_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int IW   = 9
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          start,
   fetch_decode_if.master     bus,
   output logic [PC_W-1:0]    pc,
   output logic               busy,
   output logic               halted
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;

   logic [3:0]      opcode_w;
   logic [4:0]      offset_w;
   logic [PC_W-1:0] offset_sext_w;
   logic            exec_w;

   assign opcode_w      = ir_q[IW-1:IW-4];
   assign offset_w      = ir_q[4:0];
   assign offset_sext_w = {{(PC_W-5){offset_w[4]}}, offset_w};
   assign exec_w        = (state_q == ST_EXEC);

   assign pc            = pc_q;
   assign bus.imem_addr = pc_q;
   assign bus.reg_sel   = ir_q[2:0];
   assign busy          = (state_q == ST_FETCH) || exec_w;
   assign halted        = (state_q == ST_HALT);

   // State, PC and instruction register; reset wins over every other input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and PC selection; HALT is only left through reset
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = bus.imem_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (opcode_w == OP_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_FETCH;
               if (redirect(opcode_w, bus.res_zero))
                  pc_d = pc_q + offset_sext_w;
               else
                  pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
   end

   instr_decode u_decode (
      .opcode_i    (opcode_w),
      .en_i        (exec_w),
      .cpyin_o     (bus.cpyin),
      .cpyout_o    (bus.cpyout),
      .memLoad_o   (bus.memLoad),
      .mem_write_o (bus.mem_write),
      .comp_o      (bus.comp),
      .alu_op_o    (bus.alu_op)
   );

endmodule
`default_nettype wire

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 Parameter PC_W, 8, program counter and instruction-address width.
REQ-002 Parameter IW, 9, instruction width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  level; begins execution from IDLE.
REQ-006 imem_addr  out  PC_W  instruction memory address; always equal to pc.
REQ-007 imem_data  in  IW  instruction word; synchronous ROM, valid one cycle after imem_addr.
REQ-008 res_zero  in  1  high when accumulator res equals 0; sampled in EXEC.
REQ-009 cpyin  out  1  copy selected register into res.
REQ-010 cpyout  out  1  copy res into selected register.
REQ-011 memLoad  out  1  load write_data into selected register.
REQ-012 comp  out  1  compare operation strobe.
REQ-013 reg_sel  out  3  register select, equal to instr[2:0].
REQ-014 alu_op  out  3  ALU function: 0 pass, 1 add, 2 sub, 3 and, 4 or.
REQ-015 mem_write  out  1  data-memory store strobe.
REQ-016 pc  out  PC_W  current program counter.
REQ-017 busy  out  1  high in FETCH or EXEC.
REQ-018 halted  out  1  high in HALT.

Function
REQ-019 Instruction format: opcode = instr[8:5]; operand = instr[4:0]; reg_sel = instr[2:0]; branch offset = instr[4:0], sign-extended to PC_W.
REQ-020 Opcode map: 0 CPYIN, 1 CPYOUT, 2 LOAD, 3 STORE, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 BZ, 9 JMP, A COMP, F HALT; B-E NOP.
REQ-021 FSM states: IDLE, FETCH, EXEC, HALT.
REQ-022 IDLE: start=1 -> FETCH; otherwise remain in IDLE.
REQ-023 FETCH lasts exactly one cycle and always -> EXEC; the instruction register captures imem_data on exit from FETCH.
REQ-024 EXEC lasts exactly one cycle; it -> HALT on HALT, otherwise -> FETCH.
REQ-025 Every instruction takes 2 cycles; no pipelining.
REQ-026 Control outputs (cpyin, cpyout, memLoad, comp, mem_write, alu_op) are nonzero only in EXEC, held stable for the whole cycle so that negedge-clocked consumers sample them mid-cycle.
REQ-027 Decode: CPYIN -> cpyin; CPYOUT -> cpyout; LOAD -> memLoad; STORE -> mem_write; ADD/SUB/AND/OR -> alu_op 1/2/3/4; COMP -> comp plus alu_op 2; all others -> every strobe 0 and alu_op 0.
REQ-028 PC update at the end of EXEC: BZ with res_zero=1, or JMP -> pc + sext(offset); otherwise pc + 1.
REQ-029 PC arithmetic is modulo 2^PC_W: 0xFF + 1 = 0x00, and 0x02 + sext(0x1C) = 0xFE.
REQ-030 HALT: pc frozen, all strobes 0, halted=1; start is ignored; only reset exits HALT.
REQ-031 start is ignored outside IDLE.

Reset
REQ-032 rst_n=0 at a posedge -> state IDLE, pc=0, instruction register=0, all outputs 0, regardless of current state (including mid-EXEC).
REQ-033 Reset has priority over start and all other inputs in the same cycle.

Structure
REQ-034 Shared package cpu_pkg holds the opcode constants, alu_op encodings, and FSM state type; the register file and ALU use the same encodings.
REQ-035 One combinational sub-module instr_decode (opcode in -> strobes and alu_op out) is instantiated and gated by EXEC.

Verification
REQ-036 Reset mid-EXEC of ADD -> next cycle state IDLE, pc=0, alu_op=0, busy=0.
REQ-037 ROM[0]=CPYIN r3, start=1 -> cycle 1 imem_addr=0, cycle 2 cpyin=1 with reg_sel=3, cycle 3 pc=1 and in FETCH.
REQ-038 pc=0x10, BZ offset -4: res_zero=1 -> pc=0x0C; res_zero=0 -> pc=0x11.
REQ-039 JMP +1 at pc=0xFF -> pc=0x00; sequential execution from 0xFF also wraps to 0x00.
REQ-040 HALT at pc=5 -> halted=1, pc stays 5 for 10 cycles with start pulsed, strobes 0; rst_n=0 -> IDLE.
REQ-041 Each opcode 0x0-0xF executed in turn -> exactly the strobe set of REQ-027, one EXEC cycle each; opcodes B-E assert nothing.
